// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types, widths and saturation helpers for the PE array drain path
package pe_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } collector_state_t;

  // Largest signed value representable in dw bits, widened to 64 bits
  function automatic logic signed [63:0] sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in dw bits, widened to 64 bits
  function automatic logic signed [63:0] sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Flags come straight from the count register, so they carry no combinational input path
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - requantising drain stage from a PE column to an output stream
module psum_collector
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          out_count,
  input  logic [4:0]                    shift,
  input  logic                          relu_en,
  input  logic                          psum_valid,
  input  logic [2*DATA_WIDTH-1:0]       psum_data,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [63:0] SAT_HI = sat_max(DATA_WIDTH);
  localparam logic signed [63:0] SAT_LO = sat_min(DATA_WIDTH);

  collector_state_t state;
  collector_state_t next_state;

  logic [CNT_WIDTH-1:0]  cfg_count;
  logic [4:0]            cfg_shift;
  logic                  cfg_relu;
  logic [CNT_WIDTH-1:0]  accepted;
  logic [CNT_WIDTH-1:0]  accepted_next;

  logic                  start_ok;
  logic                  sample;
  logic                  sample_last;

  logic signed [PW-1:0]  shifted;
  logic signed [63:0]    y_ext;
  logic signed [63:0]    y_relu;
  logic signed [63:0]    y_sat;
  logic [DATA_WIDTH-1:0] requant;

  logic                  stage_valid;
  logic                  stage_last;
  logic [DATA_WIDTH-1:0] stage_data;

  logic                  fifo_push_ok;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [FW-1:0]         fifo_count;
  logic                  drained;

  assign start_ok      = (state == IDLE) && start;
  assign sample        = (state == RUN) && psum_valid;
  assign accepted_next = accepted + CNT_WIDTH'(1);
  assign sample_last   = (accepted_next == cfg_count);

  // Requantise: arithmetic shift (floor), optional ReLU, then clamp into DATA_WIDTH
  always_comb begin
    shifted = $signed(psum_data) >>> cfg_shift;
    y_ext   = 64'(shifted);
    y_relu  = (cfg_relu && y_ext[63]) ? 64'sd0 : y_ext;
    y_sat   = y_relu;
    if (y_relu > SAT_HI)      y_sat = SAT_HI;
    else if (y_relu < SAT_LO) y_sat = SAT_LO;
    requant = y_sat[DATA_WIDTH-1:0];
  end

  // The PE cannot stall, so a sample that finds the FIFO full is dropped here
  assign fifo_pop     = !fifo_empty && m_tready;
  assign fifo_push_ok = stage_valid && (!fifo_full || fifo_pop);

  // Nothing left in flight once the current pop (if any) completes
  assign drained = !stage_valid &&
                   (fifo_empty || ((fifo_count == FW'(1)) && fifo_pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic for the run sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = (out_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (sample && sample_last) next_state = FLUSH;
      end
      FLUSH: begin
        if (drained) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Run configuration, accepted-sample counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_count <= '0;
      cfg_shift <= '0;
      cfg_relu  <= 1'b0;
      accepted  <= '0;
      overflow  <= 1'b0;
    end else if (start_ok) begin
      cfg_count <= out_count;
      cfg_shift <= shift;
      cfg_relu  <= relu_en;
      accepted  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (sample) accepted <= accepted_next;
      if (stage_valid && !fifo_push_ok) overflow <= 1'b1;
    end
  end

  // Single pipeline register between the requant logic and the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= sample;
      if (sample) begin
        stage_data <= requant;
        stage_last <= sample_last;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid),
    .wdata ({stage_last, stage_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head entry is masked while empty so the stream reads zero when idle
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign m_tlast  = !fifo_empty && fifo_rdata[DATA_WIDTH];
  assign busy     = (state == RUN) || (state == FLUSH);
  assign done     = (state == DONE);
  assign fill     = fifo_count;

endmodule
